// File: rtl/req_arbiter_4_if.sv
// Request/grant bundle between the request sources and the 4-way arbiter.
// The arbiter uses the slave modport; whoever drives requests uses master.
interface req_arbiter_4_if;
    logic       en;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en, mode, req,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, mode, req,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with fixed or round-robin selection, hold-until-release
// grants, a MAX_HOLD limit with forced revocation, and an enable.
module req_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    req_arbiter_4_if.slave  bus
);

    localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     r_state,     w_next_state;
    logic [3:0] r_gnt,       w_next_gnt;
    logic [1:0] r_gnt_id,    w_next_gnt_id;
    logic       r_gnt_valid, w_next_gnt_valid;
    logic       r_timeout,   w_next_timeout;
    logic [7:0] r_hold_cnt,  w_next_hold_cnt;
    logic [1:0] r_ptr,       w_next_ptr;
    logic       r_mask_vld,  w_next_mask_vld;
    logic [1:0] r_mask_id,   w_next_mask_id;

    logic [3:0] w_mask_bits;
    logic [3:0] w_req_masked;
    logic [3:0] w_req_eff;
    logic [1:0] w_win_fixed;
    logic [1:0] w_win_rr;
    logic [1:0] w_win;

    // The revoked requester is only skipped if someone else is asking.
    assign w_mask_bits  = r_mask_vld ? (4'b0001 << r_mask_id) : 4'b0000;
    assign w_req_masked = bus.req & ~w_mask_bits;
    assign w_req_eff    = (w_req_masked != 4'b0000) ? w_req_masked : bus.req;

    always_comb begin
        w_win_fixed = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_req_eff[k]) w_win_fixed = 2'(k);
        end
        // Scan the rotation backwards so the nearest requester after ptr wins.
        w_win_rr = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (w_req_eff[r_ptr + 2'(k)]) w_win_rr = r_ptr + 2'(k);
        end
        w_win = bus.mode ? w_win_rr : w_win_fixed;
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_gnt       = r_gnt;
        w_next_gnt_id    = r_gnt_id;
        w_next_gnt_valid = r_gnt_valid;
        w_next_timeout   = 1'b0;
        w_next_hold_cnt  = r_hold_cnt;
        w_next_ptr       = r_ptr;
        w_next_mask_vld  = r_mask_vld;
        w_next_mask_id   = r_mask_id;

        case (r_state)
            ST_IDLE: begin
                if (bus.en && (bus.req != 4'b0000)) begin
                    w_next_state     = ST_GRANT;
                    w_next_gnt       = 4'b0001 << w_win;
                    w_next_gnt_id    = w_win;
                    w_next_gnt_valid = 1'b1;
                    w_next_hold_cnt  = 8'd1;
                    w_next_ptr       = w_win;
                    w_next_mask_vld  = 1'b0;
                end
            end
            ST_GRANT: begin
                // Plain releases take priority over the hold limit.
                if (!bus.en || !bus.req[r_gnt_id]) begin
                    w_next_state     = ST_IDLE;
                    w_next_gnt       = 4'b0000;
                    w_next_gnt_id    = 2'd0;
                    w_next_gnt_valid = 1'b0;
                    w_next_hold_cnt  = 8'd0;
                end else if (r_hold_cnt == LP_MAX_HOLD) begin
                    w_next_state     = ST_IDLE;
                    w_next_gnt       = 4'b0000;
                    w_next_gnt_id    = 2'd0;
                    w_next_gnt_valid = 1'b0;
                    w_next_hold_cnt  = 8'd0;
                    w_next_timeout   = 1'b1;
                    w_next_mask_vld  = 1'b1;
                    w_next_mask_id   = r_gnt_id;
                end else begin
                    w_next_hold_cnt  = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_next_state     = ST_IDLE;
                w_next_gnt       = 4'b0000;
                w_next_gnt_id    = 2'd0;
                w_next_gnt_valid = 1'b0;
                w_next_hold_cnt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= 8'd0;
            r_ptr       <= 2'd3;
            r_mask_vld  <= 1'b0;
            r_mask_id   <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_gnt       <= w_next_gnt;
            r_gnt_id    <= w_next_gnt_id;
            r_gnt_valid <= w_next_gnt_valid;
            r_timeout   <= w_next_timeout;
            r_hold_cnt  <= w_next_hold_cnt;
            r_ptr       <= w_next_ptr;
            r_mask_vld  <= w_next_mask_vld;
            r_mask_id   <= w_next_mask_id;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4: one instance with MAX_HOLD = 4 for most
// scenarios and one with MAX_HOLD = 2 for the lone-requester timeout loop.
module tb_req_arbiter_4;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    req_arbiter_4_if aIf ();
    req_arbiter_4_if bIf ();

    req_arbiter_4 #(.MAX_HOLD(4)) dutA (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (aIf)
    );

    req_arbiter_4 #(.MAX_HOLD(2)) dutB (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] expIdOf(input logic [3:0] g);
        case (g)
            4'b0010: expIdOf = 2'd1;
            4'b0100: expIdOf = 2'd2;
            4'b1000: expIdOf = 2'd3;
            default: expIdOf = 2'd0;
        endcase
    endfunction

    task automatic checkGrant(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                              input logic valid, input logic to,
                              input logic [3:0] expGnt, input logic expTo);
        checkOutput({tag, ".gnt"},     32'(gnt),   32'(expGnt));
        checkOutput({tag, ".id"},      32'(id),    32'(expIdOf(expGnt)));
        checkOutput({tag, ".valid"},   32'(valid), 32'(expGnt != 4'b0000));
        checkOutput({tag, ".timeout"}, 32'(to),    32'(expTo));
    endtask

    task automatic checkA(input string tag, input logic [3:0] expGnt, input logic expTo);
        checkGrant(tag, aIf.gnt, aIf.gnt_id, aIf.gnt_valid, aIf.timeout, expGnt, expTo);
    endtask

    task automatic checkB(input string tag, input logic [3:0] expGnt, input logic expTo);
        checkGrant(tag, bIf.gnt, bIf.gnt_id, bIf.gnt_valid, bIf.timeout, expGnt, expTo);
    endtask

    task automatic applyStimulus(input logic en, input logic mode, input logic [3:0] req);
        aIf.en   = en;
        aIf.mode = mode;
        aIf.req  = req;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rrExp;
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'b1111);
        bIf.en   = 1'b1;
        bIf.mode = 1'b0;
        bIf.req  = 4'b0000;

        step();
        step();
        checkA("reset", 4'b0000, 1'b0);

        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0110);
        step();
        checkA("fixed_0110", 4'b0100, 1'b0);
        aIf.req = 4'b0010;
        step();
        checkA("fixed_rel2", 4'b0000, 1'b0);
        step();
        checkA("fixed_0010", 4'b0010, 1'b0);
        aIf.req = 4'b1111;
        step();
        checkA("fixed_hold1", 4'b0010, 1'b0);
        aIf.req = 4'b1101;
        step();
        checkA("fixed_rel1", 4'b0000, 1'b0);
        aIf.req = 4'b1111;
        step();
        checkA("fixed_1111", 4'b1000, 1'b0);
        aIf.req = 4'b0000;
        step();
        checkA("fixed_rel3", 4'b0000, 1'b0);

        // Reset mid-grant must clear the outputs before the next edge.
        aIf.req = 4'b0001;
        step();
        checkA("pre_reset_gnt", 4'b0001, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkA("async_reset", 4'b0000, 1'b0);
        #1 rst_n = 1'b1;
        step();
        checkA("post_reset_gnt", 4'b0001, 1'b0);
        aIf.req = 4'b0000;
        step();
        checkA("post_reset_rel", 4'b0000, 1'b0);

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            rrExp = 4'b0001 << (i % 4);
            step();
            checkA("rr_grant", rrExp, 1'b0);
            step();
            checkA("rr_hold", rrExp, 1'b0);
            aIf.req = 4'b1111 & ~rrExp;
            step();
            checkA("rr_gap", 4'b0000, 1'b0);
            aIf.req = 4'b1111;
        end
        aIf.req = 4'b0000;
        step();

        applyStimulus(1'b1, 1'b0, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            step();
            checkA("to_hold", 4'b1000, 1'b0);
        end
        step();
        checkA("to_pulse", 4'b0000, 1'b1);
        step();
        checkA("to_masked", 4'b0001, 1'b0);
        aIf.req = 4'b1000;
        step();
        checkA("to_rel0", 4'b0000, 1'b0);
        step();
        checkA("to_regrant3", 4'b1000, 1'b0);
        aIf.req = 4'b0000;
        step();

        // Release on the last allowed cycle is a plain release with no mask.
        aIf.req = 4'b1001;
        for (int i = 0; i < 4; i++) step();
        checkA("edge_hold4", 4'b1000, 1'b0);
        aIf.req = 4'b0001;
        step();
        checkA("edge_rel", 4'b0000, 1'b0);
        aIf.req = 4'b1001;
        step();
        checkA("edge_nomask", 4'b1000, 1'b0);
        aIf.req = 4'b0000;
        step();

        aIf.req = 4'b0100;
        step();
        checkA("en_grant", 4'b0100, 1'b0);
        aIf.en = 1'b0;
        step();
        checkA("en_drop", 4'b0000, 1'b0);
        aIf.req = 4'b1111;
        step();
        checkA("en_off1", 4'b0000, 1'b0);
        step();
        checkA("en_off2", 4'b0000, 1'b0);
        aIf.en = 1'b1;
        step();
        checkA("en_raise", 4'b1000, 1'b0);
        aIf.req = 4'b0000;
        step();

        bIf.req = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            step();
            checkB("solo_g1", 4'b0100, 1'b0);
            step();
            checkB("solo_g2", 4'b0100, 1'b0);
            step();
            checkB("solo_to", 4'b0000, 1'b1);
        end
        bIf.req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
